// File: rtl/regfile_wb_ctrl_if.sv
// Writeback requester bundle for the LC-3 register-file write port.
// ALU, load and debug writers plus the decode-stage reservation.
interface regfile_wb_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dr;
  logic [DATA_W-1:0] mem_data;
  logic              dbg_valid;
  logic              dbg_ready;
  logic [ADDR_W-1:0] dbg_dr;
  logic [DATA_W-1:0] dbg_data;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_dr;

  modport master (
    output alu_valid, alu_dr, alu_data,
    output mem_valid, mem_dr, mem_data,
    output dbg_valid, dbg_dr, dbg_data,
    output rsv_valid, rsv_dr,
    input  alu_ready, mem_ready, dbg_ready
  );

  modport slave (
    input  alu_valid, alu_dr, alu_data,
    input  mem_valid, mem_dr, mem_data,
    input  dbg_valid, dbg_dr, dbg_data,
    input  rsv_valid, rsv_dr,
    output alu_ready, mem_ready, dbg_ready
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// LC-3 register-file write-port arbiter with sequenced R1-R7 clear
// and a pending-write scoreboard for decode hazard stalls.
module regfile_wb_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 clr_start,
  regfile_wb_ctrl_if.slave     req,
  output logic                 Load,
  output logic [ADDR_W-1:0]    DR,
  output logic [DATA_W-1:0]    Din,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 clr_busy
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              rr_mem;
  logic              gnt_alu;
  logic              gnt_mem;
  logic              gnt_dbg;
  logic              xfer;
  logic [ADDR_W-1:0] sel_dr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   clr_mask;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   busy_nxt;

  always_comb begin
    state_nxt = state;
    gnt_alu   = 1'b0;
    gnt_mem   = 1'b0;
    gnt_dbg   = 1'b0;
    unique case (state)
      CLEAR: begin
        if (cnt == CNT_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (clr_start) begin
          state_nxt = CLEAR;
        end else begin
          // rr_mem set means memory wins the next ALU/memory tie
          unique case (1'b1)
            req.alu_valid && req.mem_valid: begin
              gnt_mem = rr_mem;
              gnt_alu = !rr_mem;
            end
            req.alu_valid && !req.mem_valid:
              gnt_alu = 1'b1;
            !req.alu_valid && req.mem_valid:
              gnt_mem = 1'b1;
            !req.alu_valid && !req.mem_valid && req.dbg_valid:
              gnt_dbg = 1'b1;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign req.alu_ready = gnt_alu;
  assign req.mem_ready = gnt_mem;
  assign req.dbg_ready = gnt_dbg;
  assign xfer          = gnt_alu | gnt_mem | gnt_dbg;
  assign clr_busy      = (state == CLEAR);

  always_comb begin
    sel_dr   = '0;
    sel_data = '0;
    unique case (1'b1)
      gnt_alu: begin
        sel_dr   = req.alu_dr;
        sel_data = req.alu_data;
      end
      gnt_mem: begin
        sel_dr   = req.mem_dr;
        sel_data = req.mem_data;
      end
      gnt_dbg: begin
        sel_dr   = req.dbg_dr;
        sel_data = req.dbg_data;
      end
      default: ;
    endcase
  end

  // set is applied after clear so a same-cycle reservation wins
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (xfer) clr_mask[sel_dr] = 1'b1;
    if (req.rsv_valid) set_mask[req.rsv_dr] = 1'b1;
    busy_nxt = (busy & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= CLEAR;
      cnt    <= CNT_ONE;
      rr_mem <= 1'b1;
      Load   <= 1'b0;
      DR     <= '0;
      Din    <= '0;
      busy   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        CLEAR: begin
          Load <= 1'b1;
          DR   <= cnt;
          Din  <= '0;
          cnt  <= cnt + CNT_ONE;
          busy <= '0;
        end
        RUN: begin
          if (clr_start) begin
            cnt  <= CNT_ONE;
            Load <= 1'b0;
            busy <= '0;
          end else begin
            Load <= xfer && (sel_dr != '0);
            if (xfer && (sel_dr != '0)) begin
              DR  <= sel_dr;
              Din <= sel_data;
            end
            if (gnt_alu) rr_mem <= 1'b1;
            if (gnt_mem) rr_mem <= 1'b0;
            busy <= busy_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: reference model checked every
// cycle plus hand-computed expectations for each scenario.
module tb_regfile_wb_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        clr_start = 1'b0;
  logic        Load;
  logic [2:0]  DR;
  logic [15:0] Din;
  logic [7:0]  busy;
  logic        clr_busy;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_ctrl_if #(.DATA_W(16), .ADDR_W(3)) rif ();

  regfile_wb_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .clr_start(clr_start),
    .req(rif.slave),
    .Load(Load),
    .DR(DR),
    .Din(Din),
    .busy(busy),
    .clr_busy(clr_busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clear walk index, last tie winner, pending set.
  bit       m_clr = 1'b1;
  int       m_idx = 1;
  bit       m_last_alu = 1'b1;
  bit [7:0] m_busy = '0;
  bit       m_load = 1'b0;
  int       m_dr = 0;
  int       m_din = 0;

  // 0 none, 1 alu, 2 mem, 3 dbg
  function automatic int grant();
    if (m_clr || clr_start) return 0;
    if (rif.alu_valid && rif.mem_valid) return m_last_alu ? 2 : 1;
    if (rif.alu_valid) return 1;
    if (rif.mem_valid) return 2;
    if (rif.dbg_valid) return 3;
    return 0;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    int g;
    int d;
    int v;
    if (!Reset) begin
      m_clr = 1'b1; m_idx = 1; m_last_alu = 1'b1;
      m_busy = '0; m_load = 1'b0; m_dr = 0; m_din = 0;
    end else if (m_clr) begin
      m_load = 1'b1; m_dr = m_idx; m_din = 0; m_busy = '0;
      if (m_idx == 7) m_clr = 1'b0;
      else m_idx++;
    end else if (clr_start) begin
      m_clr = 1'b1; m_idx = 1; m_load = 1'b0; m_busy = '0;
    end else begin
      g = grant();
      m_load = 1'b0;
      if (g != 0) begin
        d = (g == 1) ? int'(rif.alu_dr) : (g == 2) ? int'(rif.mem_dr)
                                                    : int'(rif.dbg_dr);
        v = (g == 1) ? int'(rif.alu_data) : (g == 2) ? int'(rif.mem_data)
                                                      : int'(rif.dbg_data);
        m_busy[d] = 1'b0;
        if (d != 0) begin
          m_load = 1'b1; m_dr = d; m_din = v;
        end
        if (g == 1) m_last_alu = 1'b1;
        if (g == 2) m_last_alu = 1'b0;
      end
      if (rif.rsv_valid) m_busy[rif.rsv_dr] = 1'b1;
      m_busy[0] = 1'b0;
    end
  end

  always @(negedge Clk) begin
    int g;
    g = grant();
    chk("m_load", Load, m_load);
    chk("m_dr", DR, m_dr);
    chk("m_din", Din, m_din);
    chk("m_busy", busy, m_busy);
    chk("m_clr_busy", clr_busy, m_clr);
    chk("m_alu_ready", rif.alu_ready, g == 1);
    chk("m_mem_ready", rif.mem_ready, g == 2);
    chk("m_dbg_ready", rif.dbg_ready, g == 3);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    rif.alu_valid = 0; rif.alu_dr = 0; rif.alu_data = 0;
    rif.mem_valid = 0; rif.mem_dr = 0; rif.mem_data = 0;
    rif.dbg_valid = 0; rif.dbg_dr = 0; rif.dbg_data = 0;
    rif.rsv_valid = 0; rif.rsv_dr = 0;
    step(); step();
    chk("rst_load", Load, 0);
    chk("rst_dr", DR, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clr_busy", clr_busy, 1);
    Reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("clr_load", Load, 1);
      chk("clr_dr", DR, i);
      chk("clr_din", Din, 0);
    end
    chk("clr_done", clr_busy, 0);
    step();
    chk("idle_load", Load, 0);

    // round robin: mem, alu, mem, alu
    rif.alu_valid = 1; rif.alu_dr = 3; rif.alu_data = 16'h1111;
    rif.mem_valid = 1; rif.mem_dr = 5; rif.mem_data = 16'h2222;
    #1 chk("rr0_mem_rdy", rif.mem_ready, 1);
    chk("rr0_alu_rdy", rif.alu_ready, 0);
    step();
    chk("rr0_dr", DR, 5); chk("rr0_din", Din, 16'h2222);
    rif.mem_data = 16'h2223;
    #1 chk("rr1_alu_rdy", rif.alu_ready, 1);
    step();
    chk("rr1_dr", DR, 3); chk("rr1_din", Din, 16'h1111);
    rif.alu_data = 16'h1112;
    step();
    chk("rr2_dr", DR, 5); chk("rr2_din", Din, 16'h2223);
    step();
    chk("rr3_dr", DR, 3); chk("rr3_din", Din, 16'h1112);
    chk("rr3_load", Load, 1);
    rif.alu_valid = 0; rif.mem_valid = 0;
    step();
    chk("rr_idle", Load, 0);

    // debug only wins when ALU and memory are quiet
    rif.dbg_valid = 1; rif.dbg_dr = 2; rif.dbg_data = 16'hBEEF;
    rif.alu_valid = 1; rif.alu_dr = 1; rif.alu_data = 16'h0A0A;
    for (int i = 0; i < 2; i++) begin
      #1 chk("dbg_blocked", rif.dbg_ready, 0);
      step();
    end
    rif.alu_valid = 0;
    #1 chk("dbg_rdy", rif.dbg_ready, 1);
    step();
    rif.dbg_valid = 0;
    chk("dbg_load", Load, 1); chk("dbg_dr", DR, 2);
    chk("dbg_din", Din, 16'hBEEF);

    // scoreboard
    rif.rsv_valid = 1; rif.rsv_dr = 4;
    step();
    rif.rsv_valid = 0;
    chk("sb_set", busy, 8'h10);
    rif.alu_valid = 1; rif.alu_dr = 4; rif.alu_data = 16'h4444;
    step();
    chk("sb_clr", busy, 8'h00);
    rif.rsv_valid = 1; rif.rsv_dr = 4;
    step();
    rif.rsv_valid = 0;
    chk("sb_setwins", busy, 8'h10);
    step();
    rif.alu_valid = 0;
    chk("sb_clr2", busy, 8'h00);
    rif.rsv_valid = 1; rif.rsv_dr = 2;
    step();
    rif.rsv_dr = 3;
    step();
    rif.rsv_dr = 0;
    step();
    rif.rsv_valid = 0;
    chk("sb_0c", busy, 8'h0C);

    // dr=0 completes the handshake but drops the write
    rif.alu_valid = 1; rif.alu_dr = 0; rif.alu_data = 16'hFFFF;
    #1 chk("r0_rdy", rif.alu_ready, 1);
    step();
    rif.alu_valid = 0;
    chk("r0_load", Load, 0);

    // clear on command with a pending ALU write
    rif.alu_valid = 1; rif.alu_dr = 6; rif.alu_data = 16'h6666;
    clr_start = 1;
    #1 chk("cs_alu_rdy", rif.alu_ready, 0);
    step();
    clr_start = 0;
    chk("cs_busy", busy, 0);
    chk("cs_clr_busy", clr_busy, 1);
    for (int i = 1; i <= 7; i++) begin
      step();
      clr_start = (i == 3);
      chk("cs_dr", DR, i);
      chk("cs_din", Din, 0);
    end
    clr_start = 0;
    #1 chk("cs_alu_rdy2", rif.alu_ready, 1);
    step();
    rif.alu_valid = 0;
    chk("cs_wr_dr", DR, 6); chk("cs_wr_din", Din, 16'h6666);

    // reset in the middle of a clear walk
    clr_start = 1;
    step();
    clr_start = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("mid_dr", DR, i);
    end
    Reset = 0;
    #1 chk("mid_rst_load", Load, 0);
    chk("mid_rst_dr", DR, 0);
    step();
    Reset = 1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("rst_restart_dr", DR, i);
      chk("rst_restart_load", Load, 1);
    end
    step();
    chk("end_clr_busy", clr_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
